// File: rtl/multicycle_muldiv.sv
// Iterative multiply/divide unit that owns HI/LO. It retires one product bit or one
// quotient bit per cycle, using a start/busy/done handshake and an MTHI/MTLO write port.
module multicycle_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state  | meaning
  // IDLE   | waiting for start; MTHI/MTLO writes accepted
  // CALC   | WIDTH shift-add / shift-subtract iterations
  // FIX    | sign correction and HI/LO write-back
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE2     = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_a_q, neg_a_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   orig_a_q, orig_a_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   quot, rem;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    b_zero_d  = b_zero_q;
    orig_a_d  = orig_a_q;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    a_neg   = ~op[0] & a[WIDTH-1];
    b_neg   = ~op[0] & b[WIDTH-1];
    // Multiply: acc = {partial sum, remaining multiplier bits}.
    // Divide: acc = {partial remainder, dividend/quotient bits}.
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};
    trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mag_b_q};
    quot    = neg_res_q ? (~acc_q[WIDTH-1:0] + ONE) : acc_q[WIDTH-1:0];
    rem     = neg_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE) : acc_q[2*WIDTH-1:WIDTH];
    prod    = neg_res_q ? (~acc_q + ONE2) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_a_d   = a_neg;
          b_zero_d  = (b == '0);
          orig_a_d  = a;
          mag_a_d   = a_neg ? (~a + ONE) : a;
          mag_b_d   = b_neg ? (~b + ONE) : b;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, mag_a_d} : {{WIDTH{1'b0}}, mag_b_d};
          cnt_d     = '0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (b_zero_q) begin
            lo_d  = '1;
            hi_d  = orig_a_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = quot;
            hi_d = rem;
          end
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      orig_a_q  <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      b_zero_q  <= b_zero_d;
      orig_a_q  <= orig_a_d;
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_multicycle_muldiv.sv
// Scoreboard bench for multicycle_muldiv: expected results are queued at issue time and
// then popped and compared by a monitor whenever done pulses.
module tb_multicycle_muldiv;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0, b = '0;
  logic          hi_we = 1'b0, lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  multicycle_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           busy_run = 0;
  logic         prev_done = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        r;
    longint      p, sx, sy, q, rm;
    logic [63:0] up;
    r.dbz = 1'b0;
    r.cyc = 0;
    r.hi  = '0;
    r.lo  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        p = sx * sy;
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        up = {32'd0, x} * {32'd0, y};
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      default: begin
        if (y == 0) begin
          r.lo = '1;
          r.hi = x;
          r.dbz = 1'b1;
        end else if (o == 2'b10) begin
          q  = sx / sy;
          rm = sx % sy;
          r.lo = q[31:0];
          r.hi = rm[31:0];
        end else begin
          r.lo = x / y;
          r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  // Monitor: pops the scoreboard on every done pulse and checks result, flag and latency.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (busy) busy_run++;
      if (done) begin
        chk("busy_low_in_done", {31'd0, busy}, 32'd0);
        chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          chk("done_latency", cyc, e.cyc);
          chk("busy_cycles", busy_run, W + 1);
          m_hi = e.hi;
          m_lo = e.lo;
        end
      end else if (div_by_zero) begin
        total++;
        bad++;
        $display("FAIL stray_dbz: got div_by_zero=1 without done expected 0 (t=%0t)", $time);
      end
      if (!busy) busy_run = 0;
      prev_done = done;
    end else begin
      busy_run = 0;
      prev_done = 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push);
    exp_t e;
    wait_idle();
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    if (push) begin
      e = model(o, x, y);
      e.cyc = cyc + W + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1);
    issue(2'b00, 32'd0, 32'h1234_5678, 1'b1);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(2'b11, 32'd7, 32'd2, 1'b1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'b11, 32'h1234, 32'd0, 1'b1);
    issue(2'b11, 32'd100, 32'd7, 1'b1);
    issue(2'b10, 32'h8000_0000, 32'd0, 1'b1);
    drain();

    // MTHI in idle leaves LO alone
    @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5_A5A5);
    chk("mthi_lo_kept", lo, m_lo);
    lo_we = 1'b1;
    wdata = 32'h0BAD_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'h0BAD_F00D);
    chk("mtlo_hi_kept", hi, 32'hA5A5_A5A5);

    // Writes and restarts while busy are ignored
    issue(2'b01, 32'h0001_2345, 32'h0000_6789, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      a = $urandom;
      b = $urandom;
      op = 2'b11;
      lo_we = 1'b1;
      hi_we = 1'b1;
      wdata = 32'h0000_DEAD;
      @(negedge clk);
    end
    start = 1'b0;
    lo_we = 1'b0;
    hi_we = 1'b0;
    drain();

    // Randomized operations, including small operands and zero divisors
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ((i % 5) == 1) rb = 32'($urandom_range(0, 9));
      if ((i % 7) == 3) ra = 32'($urandom_range(0, 9));
      if ((i % 6) == 4) rb = 32'hFFFF_FFFF;
      issue(ro, ra, rb, 1'b1);
    end
    drain();

    // Reset during CALC abandons the operation
    issue(2'b11, 32'h0FED_CBA9, 32'd13, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (45) @(negedge clk);
    chk("midrst_no_done_busy", {31'd0, busy}, 32'd0);
    issue(2'b01, 32'd3, 32'd4, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
